// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcodes, ALU codes
// and datapath select values.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH_H = 3'd1,
        FETCH_L = 3'd2,
        DECODE  = 3'd3,
        EXEC1   = 3'd4,
        EXEC2   = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_BRA = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_INC = 4'hB;
    localparam logic [3:0] OP_DEC = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_NOT    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_XOR    = 4'b1001;

    localparam logic [1:0] FUN_DEC   = 2'd0;
    localparam logic [1:0] FUN_INC   = 2'd1;
    localparam logic [1:0] FUN_LOAD  = 2'd2;
    localparam logic [1:0] FUN_CLEAR = 2'd3;

    localparam logic [1:0] ARF_SEL_PC = 2'd0;
    localparam logic [1:0] ARF_SEL_AR = 2'd2;

    localparam logic [2:0] ARF_EN_NONE = 3'b111;
    localparam logic [2:0] ARF_EN_PC   = 3'b110;
    localparam logic [2:0] ARF_EN_AR   = 3'b101;

    localparam logic [3:0] RF_EN_NONE = 4'b1111;
    localparam logic [3:0] RF_EN_ALL  = 4'b0000;

    localparam logic [1:0] MUXA_IMM = 2'd0;
    localparam logic [1:0] MUXA_MEM = 2'd1;
    localparam logic [1:0] MUXA_ALU = 2'd3;

    localparam logic [1:0] MUXB_IMM = 2'd1;

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            OP_AND:  alu_code = ALU_AND;
            OP_OR:   alu_code = ALU_OR;
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            OP_XOR:  alu_code = ALU_XOR;
            OP_NOT:  alu_code = ALU_NOT;
            default: alu_code = ALU_PASS_A;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer: fetches a 16-bit instruction in two bytes,
// decodes it and drives the register-file / ALU / memory control lines.
//
// state   | meaning
// INIT    | clear PC, R1..R4, IR
// FETCH_H | load IR[15:8] from mem[PC], PC++
// FETCH_L | load IR[7:0] from mem[PC], PC++
// DECODE  | settle IR, pick EXEC1 or HALT
// EXEC1   | first (often only) execute cycle
// EXEC2   | memory access cycle for LD / ST
// HALT    | absorbing stop state
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_Flags,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    state_t state, next_state;

    logic [3:0] opcode;
    logic [1:0] dst;
    logic [1:0] src;
    logic [3:0] dst_en;
    logic       zero;
    logic       unused_flags;

    assign opcode       = IR_Out[15:12];
    assign dst          = IR_Out[11:10];
    assign src          = IR_Out[9:8];
    assign dst_en       = ~(4'b0001 << dst);
    assign zero         = ALU_Flags[0];
    assign unused_flags = ^ALU_Flags[3:1];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Decode is skipped while Reset is low so the bus goes idle immediately,
    // not just once the state register has fallen back to INIT.
    always_comb begin
        next_state  = state;
        RF_OutASel  = 2'd0;
        RF_OutBSel  = 2'd0;
        RF_FunSel   = 2'd0;
        RF_RegSel   = RF_EN_NONE;
        ALU_FunSel  = 4'd0;
        ARF_OutCSel = 2'd0;
        ARF_OutDSel = 2'd0;
        ARF_FunSel  = 2'd0;
        ARF_RegSel  = ARF_EN_NONE;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'd0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'd0;
        MuxBSel     = 2'd0;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;

        if (Reset) begin
            case (state)
                INIT: begin
                    RF_FunSel  = FUN_CLEAR;
                    RF_RegSel  = RF_EN_ALL;
                    ARF_FunSel = FUN_CLEAR;
                    ARF_RegSel = ARF_EN_PC;
                    IR_Enable  = 1'b1;
                    IR_Funsel  = FUN_CLEAR;
                    next_state = FETCH_H;
                end
                FETCH_H, FETCH_L: begin
                    ARF_OutDSel = ARF_SEL_PC;
                    Mem_CS      = 1'b0;
                    IR_Enable   = 1'b1;
                    IR_Funsel   = FUN_LOAD;
                    IR_LH       = (state == FETCH_L);
                    ARF_FunSel  = FUN_INC;
                    ARF_RegSel  = ARF_EN_PC;
                    next_state  = (state == FETCH_H) ? FETCH_L : DECODE;
                end
                DECODE: begin
                    next_state = (opcode == OP_HLT) ? HALT : EXEC1;
                end
                EXEC1: begin
                    next_state = FETCH_H;
                    case (opcode)
                        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOT: begin
                            RF_OutASel = src;
                            RF_OutBSel = dst;
                            MuxCSel    = 1'b1;
                            ALU_FunSel = alu_code(opcode);
                            MuxASel    = MUXA_ALU;
                            RF_FunSel  = FUN_LOAD;
                            RF_RegSel  = dst_en;
                        end
                        OP_LDI: begin
                            MuxASel   = MUXA_IMM;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = dst_en;
                        end
                        OP_LD, OP_ST: begin
                            MuxBSel    = MUXB_IMM;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = ARF_EN_AR;
                            next_state = EXEC2;
                        end
                        OP_BRA: begin
                            MuxBSel    = MUXB_IMM;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = ARF_EN_PC;
                        end
                        OP_BNE: begin
                            if (!zero) begin
                                MuxBSel    = MUXB_IMM;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = ARF_EN_PC;
                            end
                        end
                        OP_INC, OP_DEC: begin
                            RF_FunSel = (opcode == OP_INC) ? FUN_INC : FUN_DEC;
                            RF_RegSel = dst_en;
                        end
                        default: ;
                    endcase
                end
                EXEC2: begin
                    next_state  = FETCH_H;
                    ARF_OutDSel = ARF_SEL_AR;
                    Mem_CS      = 1'b0;
                    if (opcode == OP_ST) begin
                        RF_OutASel = src;
                        MuxCSel    = 1'b1;
                        ALU_FunSel = ALU_PASS_A;
                        Mem_WR     = 1'b1;
                    end else begin
                        MuxASel   = MUXA_MEM;
                        RF_FunSel = FUN_LOAD;
                        RF_RegSel = dst_en;
                    end
                end
                HALT: begin
                    Halted     = 1'b1;
                    next_state = HALT;
                end
                default: next_state = INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: the sequencer drives a small behavioural datapath (RF, ARF,
// IR, byte memory, ALU) and each task checks control lines and register results.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_Flags;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  rf  [0:3];
    logic [7:0]  pc = 8'h00, ar = 8'h00, sp = 8'h00;
    logic [15:0] ir = 16'h0000;
    logic        z_flag = 1'b1;

    logic [7:0] out_c, out_d, mem_out, alu_a, alu_b, alu_out, mux_a, mux_b;

    assign IR_Out    = ir;
    assign ALU_Flags = {3'b000, z_flag};

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_Flags(ALU_Flags),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] arf_pick(input logic [1:0] s, input logic [7:0] p,
                                            input logic [7:0] a, input logic [7:0] st);
        case (s)
            2'd2:    arf_pick = a;
            2'd3:    arf_pick = st;
            default: arf_pick = p;
        endcase
    endfunction

    function automatic logic [7:0] upd(input logic [7:0] v, input logic [1:0] f,
                                       input logic [7:0] d);
        case (f)
            2'd0:    upd = v - 8'd1;
            2'd1:    upd = v + 8'd1;
            2'd2:    upd = d;
            default: upd = 8'h00;
        endcase
    endfunction

    always_comb begin
        out_c   = arf_pick(ARF_OutCSel, pc, ar, sp);
        out_d   = arf_pick(ARF_OutDSel, pc, ar, sp);
        mem_out = mem[out_d];
        alu_a   = MuxCSel ? rf[RF_OutASel] : out_c;
        alu_b   = rf[RF_OutBSel];
        case (ALU_FunSel)
            4'b0010: alu_out = ~alu_a;
            4'b0100: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0111: alu_out = alu_a & alu_b;
            4'b1000: alu_out = alu_a | alu_b;
            4'b1001: alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a;
        endcase
        case (MuxASel)
            2'd0:    mux_a = ir[7:0];
            2'd1:    mux_a = mem_out;
            2'd2:    mux_a = out_c;
            default: mux_a = alu_out;
        endcase
        case (MuxBSel)
            2'd1:    mux_b = ir[7:0];
            2'd2:    mux_b = mem_out;
            2'd3:    mux_b = alu_out;
            default: mux_b = 8'h00;
        endcase
    end

    always @(posedge Clock) begin
        for (int n = 0; n < 4; n++)
            if (!RF_RegSel[n]) rf[n] <= upd(rf[n], RF_FunSel, mux_a);
        if (!ARF_RegSel[0]) pc <= upd(pc, ARF_FunSel, mux_b);
        if (!ARF_RegSel[1]) ar <= upd(ar, ARF_FunSel, mux_b);
        if (!ARF_RegSel[2]) sp <= upd(sp, ARF_FunSel, mux_b);
        if (IR_Enable) begin
            if (IR_Funsel == 2'd3) ir <= 16'h0000;
            else if (IR_Funsel == 2'd2) begin
                if (IR_LH) ir[7:0] <= mem_out;
                else       ir[15:8] <= mem_out;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4, input logic [7:0] b5,
                             input logic [7:0] b6, input logic [7:0] b7);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
        mem[4] = b4; mem[5] = b5; mem[6] = b6; mem[7] = b7;
    endtask

    // Leaves the sequencer in FETCH_H with INIT just executed.
    task automatic start_run();
        Reset = 1'b0;
        step(1);
        Reset = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step(2);
        checks++;
        if (Mem_CS !== 1'b1 || RF_RegSel !== 4'b1111 || ARF_RegSel !== 3'b111 ||
            IR_Enable !== 1'b0 || Halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cs=%b rf_en=%b arf_en=%b ir_en=%b halt=%b, want 1 1111 111 0 0",
                     Mem_CS, RF_RegSel, ARF_RegSel, IR_Enable, Halted);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (RF_FunSel !== 2'd3 || RF_RegSel !== 4'b0000 || IR_Funsel !== 2'd3 ||
            ARF_RegSel !== 3'b110) begin
            errors++;
            $display("FAIL init_outputs: rf_fun=%0d rf_en=%b ir_fun=%0d arf_en=%b, want 3 0000 3 110",
                     RF_FunSel, RF_RegSel, IR_Funsel, ARF_RegSel);
        end
    endtask

    task automatic test_program();
        load_prog(8'h60, 8'h05, 8'hB0, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00);
        start_run();
        checks++;
        if (Mem_CS !== 1'b0 || IR_Enable !== 1'b1 || IR_LH !== 1'b0 || IR_Funsel !== 2'd2 ||
            ARF_FunSel !== 2'd1 || ARF_RegSel !== 3'b110 || pc !== 8'h00) begin
            errors++;
            $display("FAIL fetch_h: cs=%b ir_en=%b lh=%b ir_fun=%0d arf_fun=%0d arf_en=%b pc=%h, want 0 1 0 2 1 110 00",
                     Mem_CS, IR_Enable, IR_LH, IR_Funsel, ARF_FunSel, ARF_RegSel, pc);
        end
        step(1);
        checks++;
        if (IR_LH !== 1'b1 || IR_Enable !== 1'b1 || Mem_CS !== 1'b0) begin
            errors++;
            $display("FAIL fetch_l: lh=%b ir_en=%b cs=%b, want 1 1 0", IR_LH, IR_Enable, Mem_CS);
        end
        step(10);
        checks++;
        if (Halted !== 1'b1 || rf[0] !== 8'h06) begin
            errors++;
            $display("FAIL program_halt: halted=%b r1=%h, want 1 06", Halted, rf[0]);
        end
        step(3);
        checks++;
        if (Halted !== 1'b1 || Mem_CS !== 1'b1 || IR_Enable !== 1'b0 || pc !== 8'h06) begin
            errors++;
            $display("FAIL halt_absorbing: halted=%b cs=%b ir_en=%b pc=%h, want 1 1 0 06",
                     Halted, Mem_CS, IR_Enable, pc);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (Halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b, want 0", Halted);
        end
    endtask

    task automatic test_add();
        load_prog(8'h64, 8'h03, 8'h68, 8'h04, 8'h29, 8'h00, 8'hF0, 8'h00);
        start_run();
        step(11);
        checks++;
        if (ALU_FunSel !== 4'b0100 || RF_RegSel !== 4'b1011 || MuxASel !== 2'd3 ||
            MuxCSel !== 1'b1 || RF_OutASel !== 2'd1 || RF_OutBSel !== 2'd2 || RF_FunSel !== 2'd2) begin
            errors++;
            $display("FAIL add_exec1: alu=%b rf_en=%b muxa=%0d muxc=%b outa=%0d outb=%0d fun=%0d, want 0100 1011 3 1 1 2 2",
                     ALU_FunSel, RF_RegSel, MuxASel, MuxCSel, RF_OutASel, RF_OutBSel, RF_FunSel);
        end
        step(1);
        checks++;
        if (rf[2] !== 8'h07 || rf[1] !== 8'h03) begin
            errors++;
            $display("FAIL add_result: r3=%h r2=%h, want 07 03", rf[2], rf[1]);
        end
    endtask

    task automatic test_bne();
        load_prog(8'hA0, 8'h40, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        z_flag = 1'b1;
        start_run();
        step(3);
        checks++;
        if (ARF_RegSel !== 3'b111 || RF_RegSel !== 4'b1111) begin
            errors++;
            $display("FAIL bne_taken_z1: arf_en=%b rf_en=%b, want 111 1111", ARF_RegSel, RF_RegSel);
        end
        step(1);
        checks++;
        if (pc !== 8'h02) begin
            errors++;
            $display("FAIL bne_pc_z1: pc=%h, want 02", pc);
        end
        z_flag = 1'b0;
        start_run();
        step(3);
        checks++;
        if (ARF_RegSel !== 3'b110 || MuxBSel !== 2'd1 || ARF_FunSel !== 2'd2) begin
            errors++;
            $display("FAIL bne_z0: arf_en=%b muxb=%0d arf_fun=%0d, want 110 1 2",
                     ARF_RegSel, MuxBSel, ARF_FunSel);
        end
        step(1);
        checks++;
        if (pc !== 8'h40) begin
            errors++;
            $display("FAIL bne_pc_z0: pc=%h, want 40", pc);
        end
        z_flag = 1'b1;
    endtask

    task automatic test_ld();
        load_prog(8'h7C, 8'h80, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        mem[8'h80] = 8'hAA;
        start_run();
        step(3);
        checks++;
        if (ARF_RegSel !== 3'b101 || MuxBSel !== 2'd1 || ARF_FunSel !== 2'd2 || RF_RegSel !== 4'b1111) begin
            errors++;
            $display("FAIL ld_exec1: arf_en=%b muxb=%0d arf_fun=%0d rf_en=%b, want 101 1 2 1111",
                     ARF_RegSel, MuxBSel, ARF_FunSel, RF_RegSel);
        end
        step(1);
        checks++;
        if (ar !== 8'h80 || ARF_OutDSel !== 2'd2 || Mem_CS !== 1'b0 || MuxASel !== 2'd1 ||
            RF_RegSel !== 4'b0111 || Mem_WR !== 1'b0) begin
            errors++;
            $display("FAIL ld_exec2: ar=%h outd=%0d cs=%b muxa=%0d rf_en=%b wr=%b, want 80 2 0 1 0111 0",
                     ar, ARF_OutDSel, Mem_CS, MuxASel, RF_RegSel, Mem_WR);
        end
        step(1);
        checks++;
        if (rf[3] !== 8'hAA || IR_Enable !== 1'b1) begin
            errors++;
            $display("FAIL ld_result: r4=%h ir_en=%b, want aa 1", rf[3], IR_Enable);
        end
    endtask

    task automatic test_st_reset();
        load_prog(8'h64, 8'h5A, 8'h81, 8'h90, 8'hF0, 8'h00, 8'h00, 8'h00);
        start_run();
        step(8);
        checks++;
        if (Mem_WR !== 1'b1 || Mem_CS !== 1'b0 || ARF_OutDSel !== 2'd2 || ar !== 8'h90 ||
            alu_out !== 8'h5A || RF_RegSel !== 4'b1111) begin
            errors++;
            $display("FAIL st_exec2: wr=%b cs=%b outd=%0d ar=%h data=%h rf_en=%b, want 1 0 2 90 5a 1111",
                     Mem_WR, Mem_CS, ARF_OutDSel, ar, alu_out, RF_RegSel);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (Mem_WR !== 1'b0 || Mem_CS !== 1'b1 || RF_RegSel !== 4'b1111) begin
            errors++;
            $display("FAIL st_reset_now: wr=%b cs=%b rf_en=%b, want 0 1 1111", Mem_WR, Mem_CS, RF_RegSel);
        end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (RF_FunSel !== 2'd3 || RF_RegSel !== 4'b0000 || Mem_CS !== 1'b1) begin
            errors++;
            $display("FAIL st_reset_init: rf_fun=%0d rf_en=%b cs=%b, want 3 0000 1", RF_FunSel, RF_RegSel, Mem_CS);
        end
        step(1);
        checks++;
        if (IR_Enable !== 1'b1 || IR_LH !== 1'b0 || Mem_CS !== 1'b0 || pc !== 8'h00 || rf[1] !== 8'h00) begin
            errors++;
            $display("FAIL st_reset_fetch: ir_en=%b lh=%b cs=%b pc=%h r2=%h, want 1 0 0 00 00",
                     IR_Enable, IR_LH, Mem_CS, pc, rf[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_program();
        test_add();
        test_bne();
        test_ld();
        test_st_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
